// File: rtl/prog_loader.sv
// prog_loader: streams a program image from a byte interface into
// instruction memory while holding the CPU fetch stage.
//
// Stream format: LEN_HI, LEN_LO (word count N), 4*N payload bytes
// (MSB first per word), then one XOR checksum byte over the payload.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              single-cycle load request (honoured in IDLE/DONE/ERR)
//   byte_valid/ready   byte handshake, byte_data is the stream byte
//   imem_we/addr/wdata instruction-memory write port (one cycle per word)
//   cpu_hold           fetch stall while a load is running or has failed
//   done, error        sticky load outcome until next start or reset
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  // Largest legal word count: the whole address space.
  localparam logic [32:0] MAX_N = 33'd1 << ADDR_W;

  logic [2:0]  state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [16:0] word_cnt;   // one bit wider than len so k+1 never wraps
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [7:0]  csum;

  logic        accept;
  logic [15:0] n_new;
  logic [16:0] k_next;

  assign accept = byte_valid && byte_ready;
  assign n_new  = {len_hi, byte_data};
  assign k_next = word_cnt + 17'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len_hi   <= '0;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      csum     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_HI;
            word_cnt <= '0;
            byte_cnt <= '0;
            csum     <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= byte_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len <= n_new;
            if (n_new == 16'd0)
              state <= S_CHECK;
            else if ({17'd0, n_new} > MAX_N)
              state <= S_ERR;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_word <= {asm_word[23:0], byte_data};
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
              state <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_cnt <= k_next;
          state    <= (k_next < {1'b0, len}) ? S_DATA : S_CHECK;
        end
        S_CHECK: begin
          if (accept)
            state <= (byte_data == csum) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state, so reset (state=IDLE) zeroes them.
  assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = imem_we ? ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt) : '0;
  assign imem_wdata = imem_we ? asm_word : '0;
  assign cpu_hold   = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           n;       // stream length in bytes
    logic [127:0] s;       // stream, first byte in bits [127:120]
    bit           gaps;    // random byte_valid toggling
    int           nwr;
    logic [7:0]   a0, a1;
    logic [31:0]  d0, d1;
    bit           e_done, e_err, e_hold;
  } vec_t;

  vec_t vecs[6];

  int pass_cnt = 0;
  int total    = 0;

  // write monitor
  int          wr_n;
  int          br_viol;
  logic [7:0]  wr_a[4];
  logic [31:0] wr_d[4];

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_n < 4) begin
        wr_a[wr_n] = imem_addr;
        wr_d[wr_n] = imem_wdata;
      end
      if (byte_ready) br_viol = br_viol + 1;
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [127:0] mk(input int n, input logic [127:0] r);
    return r << (8 * (16 - n));
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed bytes; a byte counts as taken when valid and ready are both high
  // during the cycle ending at the next rising edge.
  task automatic feed(input logic [127:0] s, input int n, input bit gaps,
                      input int stop_at, input string nm);
    int idx = 0;
    int budget = 400;
    bit acc;
    while (idx < n && idx < stop_at && budget > 0) begin
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = s[127 - 8*idx -: 8];
      acc = byte_valid && byte_ready;
      @(negedge clk);
      if (acc) idx++;
      budget--;
    end
    byte_valid = 1'b0;
    if (budget == 0) chk({nm, " timeout"}, 64'(idx), 64'(n));
  endtask

  task automatic run_vec(input vec_t v);
    wr_n = 0;
    br_viol = 0;
    pulse_start();
    feed(v.s, v.n, v.gaps, 99, v.name);
    repeat (3) @(negedge clk);
    chk({v.name, " writes"}, 64'(wr_n), 64'(v.nwr));
    if (v.nwr > 0) begin
      chk({v.name, " addr0"}, 64'(wr_a[0]), 64'(v.a0));
      chk({v.name, " data0"}, 64'(wr_d[0]), 64'(v.d0));
    end
    if (v.nwr > 1) begin
      chk({v.name, " addr1"}, 64'(wr_a[1]), 64'(v.a1));
      chk({v.name, " data1"}, 64'(wr_d[1]), 64'(v.d1));
    end
    chk({v.name, " ready_on_write"}, 64'(br_viol), 64'd0);
    chk({v.name, " done"},  64'(done),     64'(v.e_done));
    chk({v.name, " error"}, 64'(error),    64'(v.e_err));
    chk({v.name, " hold"},  64'(cpu_hold), 64'(v.e_hold));
    chk({v.name, " ready_end"}, 64'(byte_ready), 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ready"}, 64'(byte_ready), 64'd0);
    chk({nm, " we"},    64'(imem_we),    64'd0);
    chk({nm, " addr"},  64'(imem_addr),  64'd0);
    chk({nm, " wdata"}, 64'(imem_wdata), 64'd0);
    chk({nm, " hold"},  64'(cpu_hold),   64'd0);
    chk({nm, " done"},  64'(done),       64'd0);
    chk({nm, " error"}, 64'(error),      64'd0);
  endtask

  initial begin
    vecs[0] = '{"one_word", 7, mk(7, 128'h0001DEADBEEF22), 1'b0,
                1, 8'h00, 8'h00, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"two_words", 11, mk(11, 128'h00020000000100000002_03), 1'b0,
                2, 8'h00, 8'h01, 32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"bad_csum", 7, mk(7, 128'h00011122334400), 1'b0,
                1, 8'h00, 8'h00, 32'h11223344, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{"len_257", 2, mk(2, 128'h0101), 1'b0,
                0, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"len_zero", 3, mk(3, 128'h000000), 1'b0,
                0, 8'h00, 8'h00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"two_words_gaps", 11, mk(11, 128'h00020000000100000002_03), 1'b1,
                2, 8'h00, 8'h01, 32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    wr_n = 0; br_viol = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // reset wins over a simultaneous start
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_vs_start hold", 64'(cpu_hold), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset after two payload bytes: no write, outputs cleared
    wr_n = 0;
    pulse_start();
    feed(mk(7, 128'h0001DEADBEEF22), 7, 1'b0, 4, "midrst");
    chk("midrst hold_before", 64'(cpu_hold), 64'd1);
    rst_n = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hBE;
    @(negedge clk);
    chk_all_zero("midrst");
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst writes", 64'(wr_n), 64'd0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, word address of the first loaded word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port byte_valid  input  1  byte_data valid this cycle.
REQ-007 SHALL have port byte_data  input  8  incoming stream byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  stalls the fetch stage while a load is in progress.
REQ-013 SHALL have port done  output  1  load completed with correct checksum.
REQ-014 SHALL have port error  output  1  load aborted (length or checksum failure).

Function
REQ-015 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both 1.
REQ-016 SHALL accept this stream format: LEN_HI, LEN_LO (16-bit word count N), then 4*N payload bytes, most significant byte first per word, then one checksum byte.
REQ-017 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR.
REQ-018 SHALL move from IDLE, DONE or ERR to LEN_HI on start=1, clearing done, error, the byte counter, the word counter and the checksum accumulator.
REQ-019 SHALL ignore start in LEN_HI, LEN_LO, DATA, WRITE and CHECK.
REQ-020 SHALL drive byte_ready=1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 in every other state.
REQ-021 SHALL, after LEN_LO is accepted, go to CHECK if N=0, to ERR if N > 2^ADDR_W, and otherwise to DATA.
REQ-022 SHALL XOR every accepted payload byte into an 8-bit checksum accumulator; length bytes are excluded.
REQ-023 SHALL, in DATA, shift each accepted byte into a 32-bit assembly register and go to WRITE when the 4th byte of a word is accepted.
REQ-024 SHALL, in WRITE (exactly one cycle), drive imem_we=1, imem_addr=BASE_ADDR+k (word index k, truncated to ADDR_W bits), and imem_wdata=the assembled word.
REQ-025 SHALL, from WRITE, return to DATA if k+1 < N and otherwise go to CHECK.
REQ-026 SHALL hold imem_we=0 in every state except WRITE.
REQ-027 SHALL, when the byte is accepted in CHECK, go to DONE if it equals the accumulator and otherwise to ERR.
REQ-028 SHALL hold done=1 in DONE and error=1 in ERR until the next start or reset.
REQ-029 SHALL hold cpu_hold=1 in LEN_HI, LEN_LO, DATA, WRITE, CHECK and ERR, and 0 in IDLE and DONE.
REQ-030 SHALL give a throughput of one byte per cycle, with a single one-cycle gap after each word.
REQ-031 SHALL hold state and data unchanged across any cycle where byte_valid=0.

Reset
REQ-032 SHALL, when rst_n=0 at a clock edge, set state to IDLE and drive byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done and error to 0.
REQ-033 SHALL give rst_n=0 priority over start and byte acceptance on the same edge.
REQ-034 SHALL, on reset mid-load, abandon the partial word and perform no further imem write.

Verification
REQ-035 SHALL cover this case: stream 00 01 DE AD BE EF 22 -> one imem_we pulse, addr 0, wdata DEADBEEF, then done=1 and cpu_hold=0.
REQ-036 SHALL cover this case: N=2 with words 00000001 and 00000002 and checksum 03 -> writes to addr 0 then addr 1, with byte_ready=0 on each write cycle, then done=1.
REQ-037 SHALL cover this case: stream 00 01 11 22 33 44 00 (wrong checksum) -> one write to addr 0, then error=1, cpu_hold=1, done=0.
REQ-038 SHALL cover this case: ADDR_W=8 with LEN=0101 (257) -> ERR immediately after LEN_LO, and no imem_we pulse.
REQ-039 SHALL cover this case: stream 00 00 00 (N=0, checksum 00) -> DONE with no write; and byte_valid toggling randomly on any stream -> identical writes.
REQ-040 SHALL cover this case: rst_n=0 after 2 payload bytes -> all outputs 0 and no write; a fresh start then loads correctly.
